// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array sequencer.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        FLUSH,
        DRAIN,
        DONE
    } state_e;

    function automatic int max_lanes(input int rows, input int cols);
        return (rows > cols) ? rows : cols;
    endfunction

    function automatic int kl_width(input int k_max);
        return $clog2(k_max + 1);
    endfunction

    function automatic int t_width(input int k_max, input int rows, input int cols);
        return $clog2(k_max + max_lanes(rows, cols));
    endfunction

    // Last FEED step index (F-1) for a non-zero inner dimension k.
    function automatic int feed_last(input int k, input int lanes);
        return k + lanes - 2;
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Scheduler/buffer-side signal bundle of the systolic array sequencer.
interface systolic_seq_ctrl_if
    import systolic_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int K_MAX  = 256,
    parameter int ADDR_W = 8
);
    localparam int KL_W = kl_width(K_MAX);
    localparam int RS_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                         start;
    logic [KL_W-1:0]              k_len;
    logic                         stall;
    logic                         busy;
    logic                         done;
    logic [ROWS-1:0]              a_rd_en;
    logic [ROWS-1:0][ADDR_W-1:0]  a_rd_addr;
    logic [COLS-1:0]              b_rd_en;
    logic [COLS-1:0][ADDR_W-1:0]  b_rd_addr;
    logic                         c_cap_en;
    logic [RS_W-1:0]              c_row_sel;

    modport master (
        output start, k_len, stall,
        input  busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, c_cap_en, c_row_sel
    );

    modport slave (
        input  start, k_len, stall,
        output busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, c_cap_en, c_row_sel
    );

endinterface

// File: rtl/systolic_skew_lane.sv
// One operand lane: lane LANE reads k index t-LANE while LANE <= t < LANE+k_len.
module systolic_skew_lane #(
    parameter int T_W    = 9,
    parameter int KL_W   = 9,
    parameter int ADDR_W = 8,
    parameter int LANE   = 0
) (
    input  logic [T_W-1:0]    t,
    input  logic [KL_W-1:0]   k_len,
    input  logic              active,
    output logic              en,
    output logic [ADDR_W-1:0] addr
);
    localparam logic [T_W:0] LO = (T_W+1)'(LANE);

    logic [T_W:0] t_x;
    logic [T_W:0] hi;

    assign t_x  = {1'b0, t};
    assign hi   = LO + (T_W+1)'(k_len);
    assign en   = active && (t_x >= LO) && (t_x < hi);
    assign addr = en ? ADDR_W'(t_x - LO) : '0;

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Tile sequencer: skewed A/B operand issue, pipeline flush, then row-by-row C drain.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int K_MAX     = 256,
    parameter int ADDR_W    = 8,
    parameter int FLUSH_CYC = ROWS + COLS
) (
    input  logic clk,
    input  logic rst,
    systolic_seq_ctrl_if.slave bus
);
    localparam int MAXL = max_lanes(ROWS, COLS);
    localparam int T_W  = t_width(K_MAX, ROWS, COLS);
    localparam int KL_W = kl_width(K_MAX);
    localparam int RS_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    state_e          state, state_nx;
    logic [T_W-1:0]  t, t_nx, f_last;
    logic [FC_W-1:0] fc, fc_nx;
    logic [RS_W-1:0] row, row_nx;
    logic [KL_W-1:0] k, k_nx, k_in;
    logic            zero, zero_nx;
    logic            hold, feed_act;

    logic [ROWS-1:0]             a_en_p0, a_en_p1;
    logic [ROWS-1:0][ADDR_W-1:0] a_lane_addr, a_addr_p0, a_addr_p1;
    logic [COLS-1:0]             b_en_p0, b_en_p1;
    logic [COLS-1:0][ADDR_W-1:0] b_lane_addr, b_addr_p0, b_addr_p1;
    logic                        cap_p0, cap_p1, busy_p0, busy_p1, done_p0, done_p1;
    logic [RS_W-1:0]             rsel_p0, rsel_p1;

    assign k_in   = (bus.k_len > KL_W'(K_MAX)) ? KL_W'(K_MAX) : bus.k_len;
    assign f_last = T_W'(feed_last(int'(k), MAXL));

    always_comb begin
        state_nx = state;
        t_nx     = t;
        fc_nx    = fc;
        row_nx   = row;
        k_nx     = k;
        zero_nx  = zero;
        hold     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    k_nx     = k_in;
                    t_nx     = '0;
                    fc_nx    = '0;
                    row_nx   = '0;
                    zero_nx  = (k_in == '0);
                    state_nx = (k_in == '0) ? DONE : FEED;
                end
            end
            FEED: begin
                if (bus.stall)        hold = 1'b1;
                else if (t == f_last) state_nx = FLUSH;
                else                  t_nx = t + T_W'(1);
            end
            FLUSH: begin
                if (bus.stall)                           hold = 1'b1;
                else if (fc == FC_W'(FLUSH_CYC - 1))     state_nx = DRAIN;
                else                                     fc_nx = fc + FC_W'(1);
            end
            DRAIN: begin
                if (bus.stall)                      hold = 1'b1;
                else if (row == RS_W'(ROWS - 1))    state_nx = DONE;
                else                                row_nx = row + RS_W'(1);
            end
            DONE: begin
                // A zero-length tile spends one extra cycle here so its pulse lands one cycle later.
                if (zero) zero_nx  = 1'b0;
                else      state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stage p0: output values for the step being entered
    assign feed_act = (state_nx == FEED) && !hold;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        systolic_skew_lane #(.T_W(T_W), .KL_W(KL_W), .ADDR_W(ADDR_W), .LANE(r)) u_lane (
            .t(t_nx), .k_len(k_nx), .active(feed_act), .en(a_en_p0[r]), .addr(a_lane_addr[r])
        );
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        systolic_skew_lane #(.T_W(T_W), .KL_W(KL_W), .ADDR_W(ADDR_W), .LANE(c)) u_lane (
            .t(t_nx), .k_len(k_nx), .active(feed_act), .en(b_en_p0[c]), .addr(b_lane_addr[c])
        );
    end

    always_comb begin
        a_addr_p0 = hold ? a_addr_p1 : a_lane_addr;
        b_addr_p0 = hold ? b_addr_p1 : b_lane_addr;
        cap_p0    = (state_nx == DRAIN) && !hold;
        rsel_p0   = hold ? rsel_p1 : ((state_nx == DRAIN) ? row_nx : '0);
        busy_p0   = (state_nx == FEED) || (state_nx == FLUSH) || (state_nx == DRAIN) ||
                    ((state_nx == DONE) && zero_nx);
        done_p0   = (state_nx == DONE) && !zero_nx;
    end

    // Stage p1: registered state and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            t         <= '0;
            fc        <= '0;
            row       <= '0;
            k         <= '0;
            zero      <= 1'b0;
            a_en_p1   <= '0;
            a_addr_p1 <= '0;
            b_en_p1   <= '0;
            b_addr_p1 <= '0;
            cap_p1    <= 1'b0;
            rsel_p1   <= '0;
            busy_p1   <= 1'b0;
            done_p1   <= 1'b0;
        end else begin
            state     <= state_nx;
            t         <= t_nx;
            fc        <= fc_nx;
            row       <= row_nx;
            k         <= k_nx;
            zero      <= zero_nx;
            a_en_p1   <= a_en_p0;
            a_addr_p1 <= a_addr_p0;
            b_en_p1   <= b_en_p0;
            b_addr_p1 <= b_addr_p0;
            cap_p1    <= cap_p0;
            rsel_p1   <= rsel_p0;
            busy_p1   <= busy_p0;
            done_p1   <= done_p0;
        end
    end

    assign bus.a_rd_en   = a_en_p1;
    assign bus.a_rd_addr = a_addr_p1;
    assign bus.b_rd_en   = b_en_p1;
    assign bus.b_rd_addr = b_addr_p1;
    assign bus.c_cap_en  = cap_p1;
    assign bus.c_row_sel = rsel_p1;
    assign bus.busy      = busy_p1;
    assign bus.done      = done_p1;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench for systolic_seq_ctrl: per-tile expected reads, captures and done times.
module tb_systolic_seq_ctrl;
    localparam int ROWS      = 4;
    localparam int COLS      = 4;
    localparam int K_MAX     = 256;
    localparam int ADDR_W    = 8;
    localparam int FLUSH_CYC = 8;
    localparam int MAXL      = (ROWS > COLS) ? ROWS : COLS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_seq_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .ADDR_W(ADDR_W)) bus ();

    systolic_seq_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .ADDR_W(ADDR_W), .FLUSH_CYC(FLUSH_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int v;
        int c;
    } ent_t;

    ent_t aq[ROWS][$];
    ent_t bq[COLS][$];
    ent_t cq[$];
    int   dq[$];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   win_lo = 0;
    int   win_hi = 0;
    bit   mon_en = 1'b0;
    bit   last_stall = 1'b0;
    bit   last_busy  = 1'b0;
    ent_t me;
    int   md;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input int act, input int req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a_en"},   bus.a_rd_en == '0,   int'(bus.a_rd_en),   0);
        check({tag, "_a_addr"}, bus.a_rd_addr == '0, int'(bus.a_rd_addr), 0);
        check({tag, "_b_en"},   bus.b_rd_en == '0,   int'(bus.b_rd_en),   0);
        check({tag, "_b_addr"}, bus.b_rd_addr == '0, int'(bus.b_rd_addr), 0);
        check({tag, "_cap"},    bus.c_cap_en == 1'b0, int'(bus.c_cap_en), 0);
        check({tag, "_rsel"},   bus.c_row_sel == '0, int'(bus.c_row_sel), 0);
        check({tag, "_busy"},   bus.busy == 1'b0,    int'(bus.busy),      0);
        check({tag, "_done"},   bus.done == 1'b0,    int'(bus.done),      0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a read, capture or done.
    always @(negedge clk) begin
        if (mon_en) begin
            if (last_stall && last_busy) begin
                check("stall_gate", (bus.a_rd_en == '0) && (bus.b_rd_en == '0) && !bus.c_cap_en,
                      int'({bus.a_rd_en, bus.b_rd_en, bus.c_cap_en}), 0);
            end
            for (int r = 0; r < ROWS; r++) begin
                if (bus.a_rd_en[r]) begin
                    if (aq[r].size() == 0) check($sformatf("a_extra[%0d]", r), 1'b0, int'(bus.a_rd_addr[r]), -1);
                    else begin
                        me = aq[r].pop_front();
                        check($sformatf("a_addr[%0d]", r), int'(bus.a_rd_addr[r]) == me.v, int'(bus.a_rd_addr[r]), me.v);
                        check($sformatf("a_cyc[%0d]", r), cyc == me.c, cyc, me.c);
                    end
                end else if (aq[r].size() > 0 && aq[r][0].c <= cyc) begin
                    me = aq[r].pop_front();
                    check($sformatf("a_missing[%0d]", r), 1'b0, cyc, me.c);
                end
            end
            for (int c = 0; c < COLS; c++) begin
                if (bus.b_rd_en[c]) begin
                    if (bq[c].size() == 0) check($sformatf("b_extra[%0d]", c), 1'b0, int'(bus.b_rd_addr[c]), -1);
                    else begin
                        me = bq[c].pop_front();
                        check($sformatf("b_addr[%0d]", c), int'(bus.b_rd_addr[c]) == me.v, int'(bus.b_rd_addr[c]), me.v);
                        check($sformatf("b_cyc[%0d]", c), cyc == me.c, cyc, me.c);
                    end
                end else if (bq[c].size() > 0 && bq[c][0].c <= cyc) begin
                    me = bq[c].pop_front();
                    check($sformatf("b_missing[%0d]", c), 1'b0, cyc, me.c);
                end
            end
            if (bus.c_cap_en) begin
                if (cq.size() == 0) check("c_extra", 1'b0, int'(bus.c_row_sel), -1);
                else begin
                    me = cq.pop_front();
                    check("c_row_sel", int'(bus.c_row_sel) == me.v, int'(bus.c_row_sel), me.v);
                    check("c_cyc", cyc == me.c, cyc, me.c);
                end
            end else if (cq.size() > 0 && cq[0].c <= cyc) begin
                me = cq.pop_front();
                check("c_missing", 1'b0, cyc, me.c);
            end
            if (bus.done) begin
                if (dq.size() == 0) check("done_extra", 1'b0, cyc, -1);
                else begin
                    md = dq.pop_front();
                    check("done_cyc", cyc == md, cyc, md);
                end
            end else if (dq.size() > 0 && dq[0] <= cyc) begin
                md = dq.pop_front();
                check("done_missing", 1'b0, cyc, md);
            end
            check("busy", bus.busy == ((cyc > win_lo) && (cyc < win_hi)), int'(bus.busy),
                  int'((cyc > win_lo) && (cyc < win_hi)));
            last_stall = bus.stall;
            last_busy  = bus.busy;
        end
    end

    // One tile: the model lists the cycle of every work step (stalled cycles do no work).
    task automatic run_tile(input int k, input int pct, input int st_a, input int st_b,
                            input int abort_rel, input int sp_a, input int sp_b);
        int   s, kc, fl, n, c, dcyc;
        bit   stl[0:2047];
        int   step_c[0:511];
        ent_t e;
        @(posedge clk); #1;
        s  = cyc;
        kc = (k > K_MAX) ? K_MAX : k;
        fl = (kc == 0) ? 0 : kc + MAXL - 1;
        n  = fl + FLUSH_CYC + ROWS;
        for (int i = 0; i < 2048; i++)
            stl[i] = (i > 0 && i < 1500 && pct > 0 && ($urandom_range(99) < pct)) || i == st_a || i == st_b;
        if (kc == 0) dcyc = s + 2;
        else begin
            c = s + 1;
            for (int i = 0; i < n; i++) begin
                step_c[i] = c;
                c++;
                while (stl[c - 1 - s]) c++;
            end
            dcyc = c;
            for (int r = 0; r < ROWS; r++)
                for (int j = 0; j < kc; j++) begin e.v = j; e.c = step_c[r + j]; aq[r].push_back(e); end
            for (int cc = 0; cc < COLS; cc++)
                for (int j = 0; j < kc; j++) begin e.v = j; e.c = step_c[cc + j]; bq[cc].push_back(e); end
            for (int i = 0; i < ROWS; i++) begin e.v = i; e.c = step_c[fl + FLUSH_CYC + i]; cq.push_back(e); end
        end
        dq.push_back(dcyc);
        win_lo    = s;
        win_hi    = dcyc;
        bus.start = 1'b1;
        bus.k_len = 9'(k);
        bus.stall = stl[0];
        for (int i = 1; s + i <= dcyc + 1; i++) begin
            @(posedge clk); #1;
            bus.start = (i == sp_a) || (i == sp_b);
            if (bus.start) bus.k_len = 9'($urandom_range(1, 20));
            bus.stall = stl[i];
            if (i == abort_rel) begin
                rst       = 1'b1;
                bus.stall = 1'b0;
            end
            if (abort_rel > 0 && i == abort_rel + 1) begin
                rst = 1'b0;
                for (int r = 0; r < ROWS; r++) aq[r].delete();
                for (int cc = 0; cc < COLS; cc++) bq[cc].delete();
                cq.delete();
                dq.delete();
                win_lo = 0;
                win_hi = 0;
                @(negedge clk);
                check_zero("abort");
                break;
            end
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.k_len = '0;
        bus.stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst    = 1'b0;
        mon_en = 1'b1;

        run_tile(3,   0, -1, -1, -1, -1, -1);
        run_tile(0,   0, -1, -1, -1, -1, -1);
        run_tile(3,   0,  3,  4, -1, -1, -1);
        run_tile(8,   0, -1, -1, 10, -1, -1);
        repeat (3) @(posedge clk);
        run_tile(8,   0, -1, -1, -1, -1, -1);
        run_tile(3,   0, -1, -1, -1,  3, 19);
        run_tile(256, 0, -1, -1, -1, -1, -1);
        run_tile(300, 20, -1, -1, -1, -1, -1);
        for (int i = 0; i < 6; i++)
            run_tile(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), -1, -1, -1, -1, -1);

        repeat (4) @(posedge clk);
        #1;
        for (int r = 0; r < ROWS; r++) check($sformatf("a_left[%0d]", r), aq[r].size() == 0, aq[r].size(), 0);
        for (int c = 0; c < COLS; c++) check($sformatf("b_left[%0d]", c), bq[c].size() == 0, bq[c].size(), 0);
        check("c_left", cq.size() == 0, cq.size(), 0);
        check("done_left", dq.size() == 0, dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
